// File: rtl/syscall_responder.sv
// Syscall responder: services print_int, print_string and exit requests from the CPU,
// streaming ASCII bytes to the console over a valid/ready byte channel.
module syscall_responder #(
    parameter int unsigned MAX_STR_LEN = 256,
    parameter logic [31:0] CODE_INT    = 32'd1,
    parameter logic [31:0] CODE_STR    = 32'd4,
    parameter logic [31:0] CODE_EXIT   = 32'd10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_code,
    input  logic [31:0] req_arg,
    output logic        done,
    output logic        err_unknown,
    output logic        halted,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data
);

    localparam int CW = $clog2(MAX_STR_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INT_SIGN, S_INT_DIG, S_INT_EMIT,
        S_STR_REQ, S_STR_WAIT, S_STR_EMIT, S_DONE, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mag_q, mag_d;
    logic [3:0]      pow_idx_q, pow_idx_d;
    logic [3:0]      digit_q, digit_d;
    logic            started_q, started_d;
    logic            neg_q, neg_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      byte_q, byte_d;
    logic            err_q, err_d;
    logic            halted_q, halted_d;
    logic [31:0]     pow;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            default: pow10 = 32'd1000000000;
        endcase
    endfunction

    assign pow         = pow10(pow_idx_q);
    assign mem_addr    = ptr_q;
    assign err_unknown = err_q;
    assign halted      = halted_q;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        pow_idx_d  = pow_idx_q;
        digit_d    = digit_q;
        started_d  = started_q;
        neg_d      = neg_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        byte_d     = byte_q;
        err_d      = err_q;
        halted_d   = halted_q;
        req_ready  = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_code == CODE_INT) begin
                        neg_d     = req_arg[31];
                        mag_d     = req_arg[31] ? (~req_arg + 32'd1) : req_arg;
                        pow_idx_d = 4'd9;
                        digit_d   = 4'd0;
                        started_d = 1'b0;
                        state_d   = S_INT_SIGN;
                    end else if (req_code == CODE_STR) begin
                        ptr_d   = req_arg;
                        count_d = '0;
                        state_d = S_STR_REQ;
                    end else if (req_code == CODE_EXIT) begin
                        state_d = S_HALT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_INT_SIGN: begin
                if (neg_q) begin
                    char_valid = 1'b1;
                    char_data  = 8'h2D;
                    if (char_ready) state_d = S_INT_DIG;
                end else begin
                    state_d = S_INT_DIG;
                end
            end
            // One subtraction per cycle; the digit is final once the remainder drops below p.
            S_INT_DIG: begin
                if (mag_q >= pow) begin
                    mag_d   = mag_q - pow;
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || started_q || pow_idx_q == 4'd0) begin
                    state_d = S_INT_EMIT;
                end else begin
                    pow_idx_d = pow_idx_q - 4'd1;
                end
            end
            S_INT_EMIT: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {4'h0, digit_q};
                if (char_ready) begin
                    started_d = 1'b1;
                    digit_d   = 4'd0;
                    if (pow_idx_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        pow_idx_d = pow_idx_q - 4'd1;
                        state_d   = S_INT_DIG;
                    end
                end
            end
            S_STR_REQ: begin
                mem_rd_en = 1'b1;
                state_d   = S_STR_WAIT;
            end
            S_STR_WAIT: begin
                byte_d  = mem_rd_data;
                state_d = (mem_rd_data == 8'h00) ? S_DONE : S_STR_EMIT;
            end
            S_STR_EMIT: begin
                char_valid = 1'b1;
                char_data  = byte_q;
                if (char_ready) begin
                    ptr_d   = ptr_q + 32'd1;
                    count_d = count_q + 1'b1;
                    state_d = (count_q == CW'(MAX_STR_LEN - 1)) ? S_DONE : S_STR_REQ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT: begin
                done     = ~halted_q;
                halted_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            pow_idx_q <= '0;
            digit_q   <= '0;
            started_q <= 1'b0;
            neg_q     <= 1'b0;
            ptr_q     <= '0;
            count_q   <= '0;
            byte_q    <= '0;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            pow_idx_q <= pow_idx_d;
            digit_q   <= digit_d;
            started_q <= started_d;
            neg_q     <= neg_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            halted_q  <= halted_d;
        end
    end

endmodule
